rriot_bus_arb: RTL and testbench

RRIOT_BUS_ARB -- requirements
Module: rriot_bus_arb

---
 rtl/rriot_bus_arb.sv | 245 ++++++++++++++++++++++++
 tb/tb_rriot_bus_arb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rriot_bus_arb.sv
// -----------------------------------------------------------------------------
// rriot_bus_arb
//
// Two-requester arbiter for a shared RRIOT-style bus (RAM / ROM / timer / IO
// regions selected by rs0 and cs1). One access is carried out at a time. A
// granted access drives the bus for WAIT phi2 cycles, captures the read data
// and output-enable on the last of them, and then pulses the owner's ack for
// one cycle while the bus returns to its idle, nothing-selected state.
//
// Optional feature:
//   ARB_ROUND_ROBIN_EN - when defined, simultaneous requests are granted to
//                        the requester that did not own the bus last
//                        (r0 first after reset). When undefined, r0 always
//                        wins over r1.
//
// Parameters:
//   WAIT        phi2 cycles the bus is held per access (1..15, 0 acts as 1)
//
// Ports:
//   phi2        sole clock, rising edge
//   rst         synchronous active-high reset
//   rk_req      access request from requester k (k = 0, 1)
//   rk_we_n     write when low
//   rk_addr     10-bit address
//   rk_rs0      ROM-select
//   rk_cs1      chip-select
//   rk_wdata    write data
//   rk_ack      one-cycle completion pulse to requester k
//   rk_rdata    captured read data (0 after a write), held until next ack
//   rk_rerr     read completed while bus_oe was low, held until next ack
//   bus_we_n    bus write strobe (low = write)
//   bus_a       bus address
//   bus_di      data driven into the bus target
//   bus_rs0     bus ROM-select
//   bus_cs1     bus chip-select
//   bus_do      data returned by the bus target
//   bus_oe      bus target output enable (read data valid)
//   busy        high while an access is in ACCESS or DONE
//   owner       index of the current or most recently granted requester
// -----------------------------------------------------------------------------
module rriot_bus_arb #(
    parameter int WAIT = 1
) (
    input  logic       phi2,
    input  logic       rst,

    input  logic       r0_req,
    input  logic       r0_we_n,
    input  logic [9:0] r0_addr,
    input  logic       r0_rs0,
    input  logic       r0_cs1,
    input  logic [7:0] r0_wdata,
    output logic       r0_ack,
    output logic [7:0] r0_rdata,
    output logic       r0_rerr,

    input  logic       r1_req,
    input  logic       r1_we_n,
    input  logic [9:0] r1_addr,
    input  logic       r1_rs0,
    input  logic       r1_cs1,
    input  logic [7:0] r1_wdata,
    output logic       r1_ack,
    output logic [7:0] r1_rdata,
    output logic       r1_rerr,

    output logic       bus_we_n,
    output logic [9:0] bus_a,
    output logic [7:0] bus_di,
    output logic       bus_rs0,
    output logic       bus_cs1,
    input  logic [7:0] bus_do,
    input  logic       bus_oe,

    output logic       busy,
    output logic       owner
);

    // Out-of-range WAIT values are clamped so the 4-bit counter always
    // starts at a legal, non-zero value.
    localparam int         WAIT_EFF = (WAIT < 1) ? 1 : ((WAIT > 15) ? 15 : WAIT);
    localparam logic [3:0] WAIT_LD  = WAIT_EFF[3:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;

    logic       grant_vld;
    logic       grant_sel;
    logic       last_cycle;

    logic       sel_we_n;
    logic [9:0] sel_addr;
    logic       sel_rs0;
    logic       sel_cs1;
    logic [7:0] sel_wdata;

    // -------------------------------------------------------------------------
    // Arbitration: decide who would be granted if the FSM is idle this cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_vld = r0_req | r1_req;
        grant_sel = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        // Contention goes to whoever did not own the bus last; owner resets
        // to 1 so r0 wins the first contended grant.
        if (r0_req && r1_req) begin
            grant_sel = ~owner;
        end else begin
            grant_sel = r1_req;
        end
`else
        // Fixed priority: r1 only when r0 is not asking.
        grant_sel = ~r0_req & r1_req;
`endif
    end

    // Fields of the requester that would be granted.
    always_comb begin
        sel_we_n  = r0_we_n;
        sel_addr  = r0_addr;
        sel_rs0   = r0_rs0;
        sel_cs1   = r0_cs1;
        sel_wdata = r0_wdata;
        if (grant_sel) begin
            sel_we_n  = r1_we_n;
            sel_addr  = r1_addr;
            sel_rs0   = r1_rs0;
            sel_cs1   = r1_cs1;
            sel_wdata = r1_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register.
    // -------------------------------------------------------------------------
    always_ff @(posedge phi2) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and status outputs.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        // The counter never sits at 0 inside ACCESS; "<= 1" only keeps a
        // corrupted count from stalling the bus forever.
        last_cycle = (wait_cnt <= 4'd1);
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                busy = 1'b1;
                if (last_cycle) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Bus drive, wait counter, capture and completion signalling.
    // Requester inputs are only looked at in the grant cycle; everything the
    // access needs afterwards lives in the bus output registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge phi2) begin
        if (rst) begin
            wait_cnt <= 4'd0;
            owner    <= 1'b1;
            bus_we_n <= 1'b1;
            bus_a    <= 10'd0;
            bus_di   <= 8'd0;
            bus_rs0  <= 1'b1;
            bus_cs1  <= 1'b1;
            r0_ack   <= 1'b0;
            r0_rdata <= 8'd0;
            r0_rerr  <= 1'b0;
            r1_ack   <= 1'b0;
            r1_rdata <= 8'd0;
            r1_rerr  <= 1'b0;
        end else begin
            r0_ack <= 1'b0;
            r1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner    <= grant_sel;
                        wait_cnt <= WAIT_LD;
                        bus_we_n <= sel_we_n;
                        bus_a    <= sel_addr;
                        bus_di   <= sel_wdata;
                        bus_rs0  <= sel_rs0;
                        bus_cs1  <= sel_cs1;
                    end
                end
                ACCESS: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (last_cycle) begin
                        // Last bus cycle: capture the target's response and
                        // release the bus so DONE already shows it idle.
                        // bus_we_n still holds this access's direction here.
                        if (owner) begin
                            r1_ack   <= 1'b1;
                            r1_rdata <= bus_we_n ? bus_do : 8'd0;
                            r1_rerr  <= bus_we_n & ~bus_oe;
                        end else begin
                            r0_ack   <= 1'b1;
                            r0_rdata <= bus_we_n ? bus_do : 8'd0;
                            r0_rerr  <= bus_we_n & ~bus_oe;
                        end
                        bus_we_n <= 1'b1;
                        bus_a    <= 10'd0;
                        bus_di   <= 8'd0;
                        bus_rs0  <= 1'b1;
                        bus_cs1  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rriot_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_rriot_bus_arb
//
// Directed bench for rriot_bus_arb. Two instances share the same inputs:
// dut_a with WAIT=1 and dut_b with WAIT=3. Each directed step looks only at
// the instance it is aimed at. Inputs are driven 1 time unit after a rising
// phi2 edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_rriot_bus_arb;

    logic       phi2;
    logic       rst;

    logic       r0_req, r0_we_n, r0_rs0, r0_cs1;
    logic [9:0] r0_addr;
    logic [7:0] r0_wdata;
    logic       r1_req, r1_we_n, r1_rs0, r1_cs1;
    logic [9:0] r1_addr;
    logic [7:0] r1_wdata;
    logic [7:0] bus_do;
    logic       bus_oe;

    logic       a_r0_ack, a_r0_rerr, a_r1_ack, a_r1_rerr;
    logic [7:0] a_r0_rdata, a_r1_rdata;
    logic       a_bus_we_n, a_bus_rs0, a_bus_cs1, a_busy, a_owner;
    logic [9:0] a_bus_a;
    logic [7:0] a_bus_di;

    logic       b_r0_ack, b_r0_rerr, b_r1_ack, b_r1_rerr;
    logic [7:0] b_r0_rdata, b_r1_rdata;
    logic       b_bus_we_n, b_bus_rs0, b_bus_cs1, b_busy, b_owner;
    logic [9:0] b_bus_a;
    logic [7:0] b_bus_di;

    int total;
    int bad;

    rriot_bus_arb #(.WAIT(1)) dut_a (
        .phi2(phi2), .rst(rst),
        .r0_req(r0_req), .r0_we_n(r0_we_n), .r0_addr(r0_addr),
        .r0_rs0(r0_rs0), .r0_cs1(r0_cs1), .r0_wdata(r0_wdata),
        .r0_ack(a_r0_ack), .r0_rdata(a_r0_rdata), .r0_rerr(a_r0_rerr),
        .r1_req(r1_req), .r1_we_n(r1_we_n), .r1_addr(r1_addr),
        .r1_rs0(r1_rs0), .r1_cs1(r1_cs1), .r1_wdata(r1_wdata),
        .r1_ack(a_r1_ack), .r1_rdata(a_r1_rdata), .r1_rerr(a_r1_rerr),
        .bus_we_n(a_bus_we_n), .bus_a(a_bus_a), .bus_di(a_bus_di),
        .bus_rs0(a_bus_rs0), .bus_cs1(a_bus_cs1),
        .bus_do(bus_do), .bus_oe(bus_oe),
        .busy(a_busy), .owner(a_owner)
    );

    rriot_bus_arb #(.WAIT(3)) dut_b (
        .phi2(phi2), .rst(rst),
        .r0_req(r0_req), .r0_we_n(r0_we_n), .r0_addr(r0_addr),
        .r0_rs0(r0_rs0), .r0_cs1(r0_cs1), .r0_wdata(r0_wdata),
        .r0_ack(b_r0_ack), .r0_rdata(b_r0_rdata), .r0_rerr(b_r0_rerr),
        .r1_req(r1_req), .r1_we_n(r1_we_n), .r1_addr(r1_addr),
        .r1_rs0(r1_rs0), .r1_cs1(r1_cs1), .r1_wdata(r1_wdata),
        .r1_ack(b_r1_ack), .r1_rdata(b_r1_rdata), .r1_rerr(b_r1_rerr),
        .bus_we_n(b_bus_we_n), .bus_a(b_bus_a), .bus_di(b_bus_di),
        .bus_rs0(b_bus_rs0), .bus_cs1(b_bus_cs1),
        .bus_do(bus_do), .bus_oe(bus_oe),
        .busy(b_busy), .owner(b_owner)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    task automatic tick();
        @(posedge phi2);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        r0_req = 0; r0_we_n = 1; r0_addr = '0; r0_rs0 = 1; r0_cs1 = 1; r0_wdata = '0;
        r1_req = 0; r1_we_n = 1; r1_addr = '0; r1_rs0 = 1; r1_cs1 = 1; r1_wdata = '0;
        bus_do = '0; bus_oe = 1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1;
        clear_inputs();

        // ---- Reset state (both instances) ----
        do_reset();
        chk("rst_a_busy",   a_busy, 0);
        chk("rst_a_owner",  a_owner, 1);
        chk("rst_a_we_n",   a_bus_we_n, 1);
        chk("rst_a_rs0",    a_bus_rs0, 1);
        chk("rst_a_cs1",    a_bus_cs1, 1);
        chk("rst_a_addr",   a_bus_a, 0);
        chk("rst_a_di",     a_bus_di, 0);
        chk("rst_a_acks",   {a_r0_ack, a_r1_ack}, 0);
        chk("rst_a_rdata",  {a_r0_rdata, a_r1_rdata}, 0);
        chk("rst_a_rerr",   {a_r0_rerr, a_r1_rerr}, 0);
        chk("rst_b_busy",   b_busy, 0);
        chk("rst_b_owner",  b_owner, 1);
        chk("rst_b_bus",    {b_bus_we_n, b_bus_rs0, b_bus_cs1, b_bus_a, b_bus_di}, 21'h1C_0000);

        // ---- WAIT=1 read by r0 from 0x380 (dut_a) ----
        r0_req = 1; r0_we_n = 1; r0_addr = 10'h380; r0_rs0 = 1; r0_cs1 = 0;
        bus_do = 8'h5A; bus_oe = 1;
        tick();                                   // N+1: bus driven
        r0_req = 0; r0_addr = 10'h000; r0_cs1 = 1; // late changes must not matter
        chk("rd1_bus_a",    a_bus_a, 10'h380);
        chk("rd1_we_n",     a_bus_we_n, 1);
        chk("rd1_rs0_cs1",  {a_bus_rs0, a_bus_cs1}, 2'b10);
        chk("rd1_busy",     a_busy, 1);
        chk("rd1_owner",    a_owner, 0);
        chk("rd1_noack",    {a_r0_ack, a_r1_ack}, 0);
        tick();                                   // N+2: DONE
        chk("rd1_ack",      {a_r0_ack, a_r1_ack}, 2'b10);
        chk("rd1_rdata",    a_r0_rdata, 8'h5A);
        chk("rd1_rerr",     a_r0_rerr, 0);
        chk("rd1_idle_bus", {a_bus_we_n, a_bus_rs0, a_bus_cs1, a_bus_a}, 13'h1C00);
        chk("rd1_busy_dn",  a_busy, 1);
        tick();                                   // N+3: IDLE
        chk("rd1_ack_gone", {a_r0_ack, a_r1_ack}, 0);
        chk("rd1_hold",     a_r0_rdata, 8'h5A);
        chk("rd1_busy_off", a_busy, 0);

        // ---- WAIT=3 write by r1 to 0x381 data 0xC3 (dut_b) ----
        do_reset();
        r1_req = 1; r1_we_n = 0; r1_addr = 10'h381; r1_wdata = 8'hC3; r1_rs0 = 0; r1_cs1 = 1;
        bus_oe = 0; bus_do = 8'hEE;
        tick();
        r1_req = 0; r1_wdata = 8'h00; r1_we_n = 1;
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("wr_we_n_c%0d", i), b_bus_we_n, 0);
            chk($sformatf("wr_di_c%0d", i),   b_bus_di, 8'hC3);
            chk($sformatf("wr_a_c%0d", i),    b_bus_a, 10'h381);
            chk($sformatf("wr_noack_c%0d", i), {b_r0_ack, b_r1_ack}, 0);
            tick();
        end
        chk("wr_ack",       {b_r0_ack, b_r1_ack}, 2'b01);
        chk("wr_owner",     b_owner, 1);
        chk("wr_idle_bus",  {b_bus_we_n, b_bus_di, b_bus_a}, 19'h4_0000);
        chk("wr_rdata0",    b_r1_rdata, 0);
        chk("wr_rerr0",     b_r1_rerr, 0);
        tick();
        chk("wr_ack_gone",  b_r1_ack, 0);

        // ---- Read with bus_oe low (dut_a) ----
        do_reset();
        r0_req = 1; r0_we_n = 1; r0_addr = 10'h080; r0_rs0 = 0; r0_cs1 = 0;
        bus_do = 8'hFF; bus_oe = 0;
        tick();
        r0_req = 0;
        tick();
        chk("oe_ack",   a_r0_ack, 1);
        chk("oe_rerr",  a_r0_rerr, 1);
        chk("oe_rdata", a_r0_rdata, 8'hFF);

        // ---- Both requesters held high (dut_a, WAIT=1) ----
        do_reset();
        bus_oe = 1; bus_do = 8'h11;
        r0_req = 1; r0_we_n = 1; r0_addr = 10'h010;
        r1_req = 1; r1_we_n = 1; r1_addr = 10'h020;
        for (int k = 0; k < 4; k++) begin
            logic exp_r0;
`ifdef ARB_ROUND_ROBIN_EN
            exp_r0 = ((k % 2) == 0);
`else
            exp_r0 = 1'b1;
`endif
            tick();                               // ACCESS
            chk($sformatf("arb_acc_noack_%0d", k), {a_r0_ack, a_r1_ack}, 0);
            chk($sformatf("arb_addr_%0d", k), a_bus_a, exp_r0 ? 10'h010 : 10'h020);
            tick();                               // DONE
            chk($sformatf("arb_ack_%0d", k), {a_r0_ack, a_r1_ack}, {exp_r0, ~exp_r0});
            tick();                               // IDLE, next grant
        end
        clear_inputs();

        // ---- Reset in the second ACCESS cycle of a WAIT=3 read (dut_b) ----
        do_reset();
        r0_req = 1; r0_we_n = 1; r0_addr = 10'h3FF; r0_rs0 = 0; r0_cs1 = 0;
        tick();                                   // ACCESS 1
        r0_req = 0;
        chk("abt_owner_pre", b_owner, 0);
        tick();                                   // ACCESS 2
        rst = 1;
        tick();
        rst = 0;
        chk("abt_busy",   b_busy, 0);
        chk("abt_owner",  b_owner, 1);
        chk("abt_bus",    {b_bus_we_n, b_bus_rs0, b_bus_cs1, b_bus_a}, 13'h1C00);
        chk("abt_noack",  {b_r0_ack, b_r1_ack}, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("abt_noack_late_%0d", i), {b_r0_ack, b_r1_ack, b_busy}, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
